// File: rtl/knapsack_traceback_if.sv
// knapsack_traceback_if: dp/weight table read port plus selected-item handshake
interface knapsack_traceback_if #(
    parameter int DW = 16,
    parameter int WW = 10
);
    logic          dp_rd_en;
    logic [WW-1:0] dp_rd_i;
    logic [WW-1:0] dp_rd_j;
    logic [DW-1:0] dp_rd_data;
    logic [WW-1:0] w_rd_idx;
    logic [WW-1:0] w_rd_data;
    logic          item_valid;
    logic          item_ready;
    logic [WW-1:0] item_idx;

    modport master (
        output dp_rd_en, dp_rd_i, dp_rd_j, w_rd_idx, item_valid, item_idx,
        input  dp_rd_data, w_rd_data, item_ready
    );

    modport slave (
        input  dp_rd_en, dp_rd_i, dp_rd_j, w_rd_idx, item_valid, item_idx,
        output dp_rd_data, w_rd_data, item_ready
    );
endinterface

// File: rtl/knapsack_traceback.sv
// knapsack_traceback: walks a filled 0/1-knapsack dp table from (GOODS_NUMBER, BAG_SIZE)
// back towards row 0 and streams the selected item numbers in descending order.
// Build option KNAP_TB_CHECK_EN adds a sticky err flag for weight underflow or an
// overweight result (j then saturates at 0); without it err is tied low.
module knapsack_traceback #(
    parameter int BAG_SIZE     = 8,
    parameter int GOODS_NUMBER = 4,
    parameter int DW           = 16,
    parameter int WW           = 10
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 start,
    knapsack_traceback_if.master bus,
    output logic [WW-1:0]        total_weight,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    typedef enum logic [2:0] {IDLE, RD_CUR, RD_PRV, CMP, EMIT, FIN} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] i, j, w, j_nx;
    logic [DW-1:0] cur;
    logic          sel, hs, more;

    // item i was taken when its row differs from the row above at the same capacity
    assign sel  = cur != bus.dp_rd_data;
    assign hs   = state == EMIT && bus.item_ready;
    assign more = i > WW'(1);

    assign busy           = state != IDLE;
    assign done           = state == FIN;
    assign bus.dp_rd_en   = state == RD_CUR || state == RD_PRV;
    assign bus.dp_rd_i    = state == RD_PRV ? i - WW'(1) : i;
    assign bus.dp_rd_j    = j;
    assign bus.w_rd_idx   = i;
    assign bus.item_valid = state == EMIT;
    assign bus.item_idx   = i;

`ifdef KNAP_TB_CHECK_EN
    assign j_nx = w > j ? '0 : j - w;
`else
    assign j_nx = j - w;
`endif

    // state register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else state <= state_nx;
    end

    // next-state: two reads per row, compare, optional emit, loop until row 1 is done
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = GOODS_NUMBER == 0 ? FIN : RD_CUR;
            RD_CUR:  state_nx = RD_PRV;
            RD_PRV:  state_nx = CMP;
            CMP:     state_nx = sel ? EMIT : (more ? RD_CUR : FIN);
            EMIT:    if (bus.item_ready) state_nx = more ? RD_CUR : FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath: row/column cursor, latched dp/weight reads and the running total
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            i            <= '0;
            j            <= '0;
            w            <= '0;
            cur          <= '0;
            total_weight <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    i            <= WW'(GOODS_NUMBER);
                    j            <= WW'(BAG_SIZE);
                    total_weight <= '0;
                end
                RD_PRV: begin
                    cur <= bus.dp_rd_data;
                    w   <= bus.w_rd_data;
                end
                CMP: if (!sel) i <= i - WW'(1);
                EMIT: if (bus.item_ready) begin
                    j            <= j_nx;
                    total_weight <= total_weight + w;
                    i            <= i - WW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef KNAP_TB_CHECK_EN
    // sticky consistency flag: cleared by an accepted start, set on underflow or overweight result
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if ((hs && w > j) || (done && total_weight > WW'(BAG_SIZE))) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_knapsack_traceback.sv
// tb_knapsack_traceback: randomized scoreboard bench; dp tables come from a plain 0/1-knapsack
// solver and expected picks from a direct traceback over that table.
module tb_knapsack_traceback;
    localparam int N = 4, B = 8, DW = 16, WW = 10;

    logic          clk = 0, res_n = 0, start = 0;
    logic [WW-1:0] total_weight;
    logic          busy, done, err;

    knapsack_traceback_if #(.DW(DW), .WW(WW)) bus();

    knapsack_traceback #(.BAG_SIZE(B), .GOODS_NUMBER(N), .DW(DW), .WW(WW)) dut (
        .clk(clk), .res_n(res_n), .start(start), .bus(bus),
        .total_weight(total_weight), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dp_tab [0:N][0:B];
    logic [WW-1:0] wt [0:N];
    int            val [0:N];
    int            exp_items[$];
    logic [WW-1:0] exp_tot[$];
    bit            exp_err;
    int            checks = 0, errors = 0, done_cnt = 0, item_cnt = 0, stall_left = 0;
    int            c0, nsel, t;
    bit            rnd_ready = 0, mon_stalled = 0;
    logic [WW-1:0] mon_held = '0;

    function automatic logic [DW-1:0] dp_at(input int r, input int c);
        return (r >= 0 && r <= N && c >= 0 && c <= B) ? dp_tab[r][c] : '0;
    endfunction

    function automatic logic [WW-1:0] wt_at(input int r);
        return (r >= 1 && r <= N) ? wt[r] : '0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // solve the knapsack for the current weights/values: fixed=1 uses weights 2..5, values 3..6
    task automatic build(input bit fixed);
        int best, cand;
        wt[0] = '0;
        for (int r = 1; r <= N; r++) begin
            wt[r]  = fixed ? WW'(r + 1) : WW'($urandom_range(1, 6));
            val[r] = fixed ? r + 2 : int'($urandom_range(1, 9));
        end
        for (int c = 0; c <= B; c++) dp_tab[0][c] = '0;
        for (int r = 1; r <= N; r++)
            for (int c = 0; c <= B; c++) begin
                best = int'(dp_tab[r-1][c]);
                if (int'(wt[r]) <= c) begin
                    cand = int'(dp_tab[r-1][c - int'(wt[r])]) + val[r];
                    if (cand > best) best = cand;
                end
                dp_tab[r][c] = DW'(best);
            end
    endtask

    task automatic zero_table();
        for (int r = 0; r <= N; r++)
            for (int c = 0; c <= B; c++) dp_tab[r][c] = '0;
    endtask

    // reference traceback: expected picks, total and err for the current table
    task automatic model(output int n);
        logic [WW-1:0] jj, tot;
        jj = WW'(B);
        tot = '0;
        n = 0;
        exp_err = 0;
        for (int r = N; r >= 1; r--)
            if (dp_at(r, int'(jj)) != dp_at(r - 1, int'(jj))) begin
                exp_items.push_back(r);
                n++;
`ifdef KNAP_TB_CHECK_EN
                if (wt[r] > jj) begin
                    exp_err = 1;
                    jj = '0;
                end else jj = jj - wt[r];
`else
                jj = jj - wt[r];
`endif
                tot = tot + wt[r];
            end
`ifdef KNAP_TB_CHECK_EN
        if (tot > WW'(B)) exp_err = 1;
`endif
        exp_tot.push_back(tot);
    endtask

    // memory model: registered reads, garbage when not strobed
    always @(posedge clk) begin
        bus.dp_rd_data <= bus.dp_rd_en ? dp_at(int'(bus.dp_rd_i), int'(bus.dp_rd_j)) : DW'($urandom);
        bus.w_rd_data  <= bus.dp_rd_en ? wt_at(int'(bus.w_rd_idx)) : WW'($urandom);
    end

    // consumer: optional hold-off on the first emit, else always-ready or random ready
    initial begin
        bus.item_ready = 1;
        forever begin
            @(posedge clk);
            #2;
            if (bus.item_valid && stall_left > 0) begin
                bus.item_ready = 0;
                stall_left--;
            end else bus.item_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor: compares every accepted item and every done pulse against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!res_n) mon_stalled = 0;
            else begin
                if (bus.item_valid && mon_stalled) chk("item_idx_hold", bus.item_idx, mon_held);
                if (bus.item_valid && bus.item_ready) begin
                    item_cnt++;
                    if (exp_items.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_item: got idx %0d, expected none", bus.item_idx);
                    end else chk("item_idx", bus.item_idx, exp_items.pop_front());
                end
                mon_stalled = bus.item_valid && !bus.item_ready;
                mon_held = bus.item_idx;
                if (done) begin
                    done_cnt++;
                    if (exp_tot.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_done: got done, expected none (total %0d)", total_weight);
                    end else chk("total_weight", total_weight, exp_tot.pop_front());
                    chk("items_left", exp_items.size(), 0);
                end
            end
        end
    end

    task automatic run(input int stall, input bit restart, input bit rnd, input bit chk_lat);
        int n, lat, d0;
        model(n);
        d0 = done_cnt;
        stall_left = stall;
        rnd_ready = rnd;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        lat = 1;
        chk("err_clear_on_start", err, 0);
        chk("busy_running", busy, 1);
        while (!done && lat < 500) begin
            @(negedge clk);
            lat++;
            start = restart && lat == 2;
        end
        start = 0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: no done after %0d cycles, expected done", lat);
        end else if (chk_lat) chk("latency", lat, 3 * N + 1 + n + stall);
        rnd_ready = 0;
        @(negedge clk);
        chk("done_once", done_cnt - d0, 1);
        chk("done_width", done, 0);
        chk("err", err, exp_err);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        build(1);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_item_valid", bus.item_valid, 0);
        chk("rst_dp_rd_en", bus.dp_rd_en, 0);
        chk("rst_total", total_weight, 0);
        chk("rst_err", err, 0);
        res_n = 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        c0 = item_cnt;
        run(0, 0, 0, 1);
        chk("fixed_items", item_cnt - c0, 2);
        chk("fixed_total", total_weight, 8);

        c0 = item_cnt;
        run(5, 0, 0, 1);
        chk("stall_items", item_cnt - c0, 2);
        chk("stall_total", total_weight, 8);

        run(0, 1, 0, 1);
        chk("restart_total", total_weight, 8);

        zero_table();
        c0 = item_cnt;
        run(0, 0, 0, 1);
        chk("zero_items", item_cnt - c0, 0);
        chk("zero_total", total_weight, 0);

        for (int k = 0; k < 6; k++) begin
            build(0);
            run(0, 0, k % 2 == 1, k % 2 == 0);
        end

        build(1);
        model(nsel);
        c0 = done_cnt;
        stall_left = 1000;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        t = 0;
        while (!bus.item_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("reached_emit", bus.item_valid, 1);
        res_n = 0;
        #1;
        chk("arst_item_valid", bus.item_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_dp_rd_en", bus.dp_rd_en, 0);
        exp_items.delete();
        exp_tot.delete();
        stall_left = 0;
        repeat (3) @(negedge clk);
        res_n = 1;
        repeat (5) @(negedge clk);
        chk("arst_no_done", done_cnt - c0, 0);
        chk("arst_stay_idle", busy, 0);
        chk("arst_total", total_weight, 0);

`ifdef KNAP_TB_CHECK_EN
        build(1);
        zero_table();
        dp_tab[N][B] = 1;
        dp_tab[N-1][3] = 1;
        run(0, 0, 0, 1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        build(1);
        run(0, 0, 0, 1);
        chk("err_after_clean", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
